// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch-side PC sequencer.
package fetch_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    REDIRECT = 2'd2
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
  } inflight_t;

endpackage

// File: rtl/pred_fifo.sv
// In-flight prediction FIFO: DEPTH entries, synchronous clear, head read combinationally.
module pred_fifo #(
  parameter int W     = 65,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [W-1:0]                 wdata_i,
  output logic [W-1:0]                 rdata_o,
  output logic                         valid_o,
  output logic                         full_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [PW-1:0]           rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    do_push, do_pop;

  assign valid_o = (cnt_q != '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;
  assign rdata_o = valid_o ? mem_q[rd_q] : '0;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && valid_o;

  // Clear wins over any push/pop in the same cycle.
  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + PW'(1);
      if (do_pop)  rd_d = rd_q + PW'(1);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear_i) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/fetch_pc_sequencer.sv
// Fetch PC generator: IDLE/RUN/REDIRECT FSM, next-PC select, and BTB-hit tracking FIFO.
module fetch_pc_sequencer #(
  parameter int               XLEN     = fetch_pkg::XLEN,
  parameter logic [XLEN-1:0]  RESET_PC = '0,
  parameter int               DEPTH    = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        stall,
  output logic                        fetch_valid,
  output logic [XLEN-1:0]             fetch_pc,
  input  logic                        predicted_taken,
  input  logic [XLEN-1:0]             predicted_target,
  input  logic                        btb_hit,
  input  logic                        flush,
  input  logic [XLEN-1:0]             recover_pc,
  input  logic                        resolve_pop,
  output logic                        head_valid,
  output logic [XLEN-1:0]             head_pc,
  output logic [XLEN-1:0]             head_pred_target,
  output logic                        head_pred_taken,
  output logic [$clog2(DEPTH+1)-1:0]  inflight_count,
  output logic                        inflight_full
);

  localparam int W = 2*XLEN + 1;

  fetch_pkg::state_e state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [W-1:0]      fifo_wdata, fifo_rdata;
  logic              fifo_push;

  assign fetch_pc    = pc_q;
  assign fetch_valid = (state_q == fetch_pkg::RUN) && !stall && !inflight_full;

  // Flush has top priority; a blocked fetch holds the PC it could not issue.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      fetch_pkg::IDLE:     state_d = fetch_pkg::RUN;
      fetch_pkg::REDIRECT: state_d = fetch_pkg::RUN;
      default:             state_d = fetch_pkg::RUN;
    endcase
    if (flush) begin
      state_d = fetch_pkg::REDIRECT;
      pc_d    = recover_pc;
    end else if (fetch_valid) begin
      if (btb_hit && predicted_taken) pc_d = predicted_target;
      else                            pc_d = pc_q + XLEN'(fetch_pkg::INSTR_BYTES);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= fetch_pkg::IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign fifo_push  = fetch_valid && btb_hit && !flush;
  assign fifo_wdata = {pc_q, predicted_taken, predicted_target};

  pred_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .clear_i (flush),
    .push_i  (fifo_push),
    .pop_i   (resolve_pop),
    .wdata_i (fifo_wdata),
    .rdata_o (fifo_rdata),
    .valid_o (head_valid),
    .full_o  (inflight_full),
    .count_o (inflight_count)
  );

  assign head_pc          = fifo_rdata[W-1 -: XLEN];
  assign head_pred_taken  = fifo_rdata[XLEN];
  assign head_pred_target = fifo_rdata[XLEN-1:0];

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Directed scenarios plus randomized traffic checked against a queue-based reference model.
module tb_fetch_pc_sequencer;

  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall, predicted_taken, btb_hit, flush, resolve_pop;
  logic [31:0] predicted_target, recover_pc;
  logic        fetch_valid, head_valid, head_pred_taken, inflight_full;
  logic [31:0] fetch_pc, head_pc, head_pred_target;
  logic [2:0]  inflight_count;

  fetch_pc_sequencer #(.XLEN(XLEN), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .predicted_taken(predicted_taken), .predicted_target(predicted_target), .btb_hit(btb_hit),
    .flush(flush), .recover_pc(recover_pc), .resolve_pop(resolve_pop),
    .head_valid(head_valid), .head_pc(head_pc), .head_pred_target(head_pred_target),
    .head_pred_taken(head_pred_taken), .inflight_count(inflight_count), .inflight_full(inflight_full)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: PC, number of remaining no-fetch cycles, queue of outstanding hits.
  logic [31:0]          m_pc;
  int                   m_wait;
  fetch_pkg::inflight_t m_q[$];

  function automatic bit m_fv();
    return (m_wait == 0) && !stall && (m_q.size() < DEPTH);
  endfunction

  task automatic model_reset();
    m_pc   = RESET_PC;
    m_wait = 1;
    m_q.delete();
  endtask

  task automatic drive(input bit st, input bit hit, input bit tk, input logic [31:0] tg,
                       input bit pop, input bit fl, input logic [31:0] rpc);
    stall = st; btb_hit = hit; predicted_taken = tk; predicted_target = tg;
    resolve_pop = pop; flush = fl; recover_pc = rpc;
    #1;
  endtask

  task automatic idle_in();
    drive(0, 0, 0, 32'h0, 0, 0, 32'h0);
  endtask

  task automatic tick();
    bit fv;
    fetch_pkg::inflight_t e;
    fv = m_fv();
    @(posedge clk);
    if (flush) begin
      m_pc = recover_pc;
      m_q.delete();
      m_wait = 1;
    end else begin
      if (resolve_pop && m_q.size() > 0) void'(m_q.pop_front());
      if (fv && btb_hit) begin
        e.pc = m_pc; e.pred_taken = predicted_taken; e.pred_target = predicted_target;
        m_q.push_back(e);
      end
      if (fv) m_pc = (btb_hit && predicted_taken) ? predicted_target : m_pc + 32'd4;
      if (m_wait > 0) m_wait--;
    end
    #1;
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_in();
    #3;
    n_vec++; if (fetch_valid !== 1'b0) begin n_err++; $display("FAIL rst_fv: got %b want 0", fetch_valid); end
    n_vec++; if (fetch_pc !== RESET_PC) begin n_err++; $display("FAIL rst_pc: got %h want %h", fetch_pc, RESET_PC); end
    n_vec++; if (head_valid !== 1'b0) begin n_err++; $display("FAIL rst_hv: got %b want 0", head_valid); end
    n_vec++; if (inflight_count !== 3'd0) begin n_err++; $display("FAIL rst_cnt: got %0d want 0", inflight_count); end
    n_vec++; if (inflight_full !== 1'b0) begin n_err++; $display("FAIL rst_full: got %b want 0", inflight_full); end
    n_vec++; if (head_pc !== 32'h0) begin n_err++; $display("FAIL rst_hpc: got %h want 0", head_pc); end
    n_vec++; if (head_pred_target !== 32'h0) begin n_err++; $display("FAIL rst_htg: got %h want 0", head_pred_target); end
    n_vec++; if (head_pred_taken !== 1'b0) begin n_err++; $display("FAIL rst_htk: got %b want 0", head_pred_taken); end
    release_reset();
    n_vec++; if (fetch_valid !== 1'b0) begin n_err++; $display("FAIL idle_fv: got %b want 0", fetch_valid); end
    tick();
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (fetch_valid !== 1'b1) begin n_err++; $display("FAIL seq_fv%0d: got %b want 1", i, fetch_valid); end
      n_vec++; if (fetch_pc !== 32'(i*4)) begin n_err++; $display("FAIL seq_pc%0d: got %h want %h", i, fetch_pc, 32'(i*4)); end
      n_vec++; if (head_valid !== 1'b0) begin n_err++; $display("FAIL seq_hv%0d: got %b want 0", i, head_valid); end
      tick();
    end
  endtask

  task automatic test_taken_hit();
    drive(0, 0, 0, 0, 0, 1, 32'h40); tick();
    idle_in(); tick();
    drive(0, 1, 1, 32'h80, 0, 0, 0);
    n_vec++; if (fetch_pc !== 32'h40 || fetch_valid !== 1'b1) begin n_err++; $display("FAIL tk_pre: got pc %h fv %b want 40/1", fetch_pc, fetch_valid); end
    tick(); idle_in();
    n_vec++; if (fetch_pc !== 32'h80) begin n_err++; $display("FAIL tk_pc: got %h want 80", fetch_pc); end
    n_vec++; if (head_pc !== 32'h40) begin n_err++; $display("FAIL tk_hpc: got %h want 40", head_pc); end
    n_vec++; if (head_pred_target !== 32'h80) begin n_err++; $display("FAIL tk_htg: got %h want 80", head_pred_target); end
    n_vec++; if (head_pred_taken !== 1'b1) begin n_err++; $display("FAIL tk_htk: got %b want 1", head_pred_taken); end
    n_vec++; if (inflight_count !== 3'd1) begin n_err++; $display("FAIL tk_cnt: got %0d want 1", inflight_count); end
  endtask

  task automatic test_not_taken();
    drive(0, 0, 0, 0, 0, 1, 32'h44); tick();
    idle_in(); tick();
    drive(0, 1, 0, 32'h1234, 0, 0, 0);
    n_vec++; if (inflight_count !== 3'd0) begin n_err++; $display("FAIL nt_clr: got %0d want 0", inflight_count); end
    tick(); idle_in();
    n_vec++; if (fetch_pc !== 32'h48) begin n_err++; $display("FAIL nt_pc: got %h want 48", fetch_pc); end
    n_vec++; if (head_pc !== 32'h44 || head_pred_taken !== 1'b0) begin n_err++; $display("FAIL nt_head: got %h/%b want 44/0", head_pc, head_pred_taken); end
    n_vec++; if (inflight_count !== 3'd1) begin n_err++; $display("FAIL nt_cnt: got %0d want 1", inflight_count); end
    drive(0, 0, 0, 0, 1, 0, 0); tick(); idle_in();
    n_vec++; if (inflight_count !== 3'd0 || head_valid !== 1'b0) begin n_err++; $display("FAIL nt_pop: got cnt %0d hv %b want 0/0", inflight_count, head_valid); end
    n_vec++; if (fetch_pc !== 32'h4C) begin n_err++; $display("FAIL nt_pc2: got %h want 4c", fetch_pc); end
  endtask

  task automatic test_flush();
    drive(0, 1, 1, 32'h48, 0, 0, 0); tick();
    drive(0, 1, 1, 32'h999, 1, 1, 32'h50);
    n_vec++; if (inflight_count !== 3'd1 || fetch_pc !== 32'h48) begin n_err++; $display("FAIL fl_pre: got cnt %0d pc %h want 1/48", inflight_count, fetch_pc); end
    tick(); idle_in();
    n_vec++; if (fetch_valid !== 1'b0) begin n_err++; $display("FAIL fl_bubble: got %b want 0", fetch_valid); end
    n_vec++; if (fetch_pc !== 32'h50) begin n_err++; $display("FAIL fl_pc: got %h want 50", fetch_pc); end
    n_vec++; if (inflight_count !== 3'd0 || head_valid !== 1'b0) begin n_err++; $display("FAIL fl_clr: got cnt %0d hv %b want 0/0", inflight_count, head_valid); end
    tick();
    n_vec++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h50) begin n_err++; $display("FAIL fl_res: got fv %b pc %h want 1/50", fetch_valid, fetch_pc); end
    tick();
    n_vec++; if (fetch_pc !== 32'h54) begin n_err++; $display("FAIL fl_pc2: got %h want 54", fetch_pc); end
  endtask

  task automatic test_full();
    logic [31:0] base;
    base = m_pc;
    for (int i = 0; i < DEPTH; i++) begin drive(0, 1, 0, 32'hDEAD0000, 0, 0, 0); tick(); end
    n_vec++; if (inflight_full !== 1'b1 || inflight_count !== 3'(DEPTH)) begin n_err++; $display("FAIL full_flag: got %b/%0d want 1/%0d", inflight_full, inflight_count, DEPTH); end
    n_vec++; if (fetch_valid !== 1'b0) begin n_err++; $display("FAIL full_fv: got %b want 0", fetch_valid); end
    n_vec++; if (head_pc !== base) begin n_err++; $display("FAIL full_head: got %h want %h", head_pc, base); end
    tick(); tick();
    n_vec++; if (fetch_pc !== base + 32'd16 || inflight_count !== 3'(DEPTH)) begin n_err++; $display("FAIL full_hold: got pc %h cnt %0d want %h/%0d", fetch_pc, inflight_count, base + 32'd16, DEPTH); end
    drive(0, 1, 0, 0, 1, 0, 0);
    n_vec++; if (fetch_valid !== 1'b0) begin n_err++; $display("FAIL full_popfv: got %b want 0", fetch_valid); end
    tick(); idle_in();
    n_vec++; if (fetch_valid !== 1'b1 || fetch_pc !== base + 32'd16) begin n_err++; $display("FAIL full_resume: got fv %b pc %h want 1/%h", fetch_valid, fetch_pc, base + 32'd16); end
    n_vec++; if (inflight_count !== 3'(DEPTH-1) || head_pc !== base + 32'd4) begin n_err++; $display("FAIL full_after: got cnt %0d hpc %h want %0d/%h", inflight_count, head_pc, DEPTH-1, base + 32'd4); end
    drive(0, 1, 1, 32'h600, 1, 0, 0);
    tick(); idle_in();
    n_vec++; if (inflight_count !== 3'(DEPTH-1) || fetch_pc !== 32'h600) begin n_err++; $display("FAIL pushpop: got cnt %0d pc %h want %0d/600", inflight_count, fetch_pc, DEPTH-1); end
  endtask

  task automatic test_stall_wrap();
    drive(0, 0, 0, 0, 0, 1, 32'hFFFF_FFF4); tick();
    idle_in(); tick(); tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 1, 32'h700, 0, 0, 0);
      n_vec++; if (fetch_valid !== 1'b0 || fetch_pc !== 32'hFFFF_FFF8) begin n_err++; $display("FAIL stall%0d: got fv %b pc %h want 0/fffffff8", i, fetch_valid, fetch_pc); end
      tick();
    end
    idle_in();
    n_vec++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'hFFFF_FFF8) begin n_err++; $display("FAIL unstall: got fv %b pc %h want 1/fffffff8", fetch_valid, fetch_pc); end
    tick();
    n_vec++; if (fetch_pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_pre: got %h want fffffffc", fetch_pc); end
    tick();
    n_vec++; if (fetch_pc !== 32'h0 || fetch_valid !== 1'b1) begin n_err++; $display("FAIL wrap: got pc %h fv %b want 0/1", fetch_pc, fetch_valid); end
  endtask

  task automatic test_flush_redirect();
    drive(0, 0, 0, 0, 0, 1, 32'h200); tick();
    drive(0, 0, 0, 0, 0, 1, 32'h300);
    n_vec++; if (fetch_valid !== 1'b0) begin n_err++; $display("FAIL rd_fv: got %b want 0", fetch_valid); end
    tick(); idle_in();
    n_vec++; if (fetch_valid !== 1'b0 || fetch_pc !== 32'h300) begin n_err++; $display("FAIL rd_bubble: got fv %b pc %h want 0/300", fetch_valid, fetch_pc); end
    tick();
    n_vec++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h300) begin n_err++; $display("FAIL rd_res: got fv %b pc %h want 1/300", fetch_valid, fetch_pc); end
  endtask

  task automatic test_flush_idle();
    reset = 1'b1; idle_in();
    release_reset();
    drive(0, 0, 0, 0, 0, 1, 32'h100);
    n_vec++; if (fetch_valid !== 1'b0) begin n_err++; $display("FAIL fi_fv: got %b want 0", fetch_valid); end
    tick(); idle_in();
    n_vec++; if (fetch_valid !== 1'b0 || fetch_pc !== 32'h100) begin n_err++; $display("FAIL fi_bubble: got fv %b pc %h want 0/100", fetch_valid, fetch_pc); end
    tick();
    n_vec++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h100) begin n_err++; $display("FAIL fi_res: got fv %b pc %h want 1/100", fetch_valid, fetch_pc); end
  endtask

  task automatic test_random();
    fetch_pkg::inflight_t h;
    bit exp_fv;
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 55, $urandom_range(0, 1) == 1,
            $urandom & 32'hFFFF_FFFC, $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 4,
            $urandom & 32'hFFFF_FFFC);
      exp_fv = m_fv();
      h = (m_q.size() > 0) ? m_q[0] : '0;
      n_vec++; if (fetch_valid !== exp_fv) begin n_err++; $display("FAIL rnd_fv c%0d: got %b want %b", c, fetch_valid, exp_fv); end
      n_vec++; if (fetch_pc !== m_pc) begin n_err++; $display("FAIL rnd_pc c%0d: got %h want %h", c, fetch_pc, m_pc); end
      n_vec++; if (inflight_count !== 3'(m_q.size())) begin n_err++; $display("FAIL rnd_cnt c%0d: got %0d want %0d", c, inflight_count, m_q.size()); end
      n_vec++; if (inflight_full !== (m_q.size() == DEPTH)) begin n_err++; $display("FAIL rnd_full c%0d: got %b want %b", c, inflight_full, m_q.size() == DEPTH); end
      n_vec++; if (head_valid !== (m_q.size() > 0)) begin n_err++; $display("FAIL rnd_hv c%0d: got %b want %b", c, head_valid, m_q.size() > 0); end
      n_vec++; if ({head_pc, head_pred_taken, head_pred_target} !== {h.pc, h.pred_taken, h.pred_target}) begin
        n_err++; $display("FAIL rnd_head c%0d: got %h/%b/%h want %h/%b/%h", c, head_pc, head_pred_taken, head_pred_target, h.pc, h.pred_taken, h.pred_target);
      end
      tick();
    end
  endtask

  initial begin
    idle_in();
    #1 reset = 1'b1;
    test_reset();
    test_taken_hit();
    test_not_taken();
    test_flush();
    test_full();
    test_stall_wrap();
    test_flush_redirect();
    test_flush_idle();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
